// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter and the hazard unit.
// Holds the arbiter state encoding and the load/store opcodes both blocks decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// data-memory stage: one transaction in flight, DM priority with an IF streak guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int STREAK_W      = $clog2(MAX_DM_STREAK + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  // instruction fetch requester
  input  logic                IF_REQ,
  input  logic [ADDR_W-1:0]   IF_ADDR,
  input  logic                IF_KILL,
  output logic                IF_RDY,
  output logic [XLEN-1:0]     IF_RDATA,
  output logic                IF_STALL,
  // data-memory requester
  input  logic                DM_REQ,
  input  logic                DM_WE,
  input  logic [ADDR_W-1:0]   DM_ADDR,
  input  logic [XLEN-1:0]     DM_WDATA,
  input  logic [XLEN/8-1:0]   DM_WSTRB,
  output logic                DM_RDY,
  output logic [XLEN-1:0]     DM_RDATA,
  output logic                DM_STALL,
  // unified memory port
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [XLEN-1:0]     MEM_WDATA,
  output logic [XLEN/8-1:0]   MEM_WSTRB,
  input  logic                MEM_RDY,
  input  logic [XLEN-1:0]     MEM_RDATA
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_e          state_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic                kill_reg;
  logic                mem_req_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [XLEN-1:0]     mem_wdata_reg;
  logic [XLEN/8-1:0]   mem_wstrb_reg;

  logic grant_dm;
  logic grant_if;

  // DM normally wins; once it has won MAX_DM_STREAK times in a row over a waiting IF, IF goes next.
  assign grant_dm = DM_REQ && (!IF_REQ || (streak_reg < STREAK_MAX));
  assign grant_if = IF_REQ && !grant_dm;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      kill_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_dm) begin
            state_reg     <= BUSY_DM;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= DM_WE;
            mem_addr_reg  <= DM_ADDR;
            mem_wdata_reg <= DM_WDATA;
            mem_wstrb_reg <= DM_WSTRB;
            if (!IF_REQ) begin
              streak_reg <= '0;
            end else if (streak_reg != STREAK_MAX) begin
              streak_reg <= streak_reg + 1'b1;
            end
          end else if (grant_if) begin
            state_reg     <= BUSY_IF;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= IF_ADDR;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            streak_reg    <= '0;
            kill_reg      <= 1'b0;
          end
        end
        BUSY_IF: begin
          if (MEM_RDY) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            kill_reg    <= 1'b0;
          end else if (IF_KILL) begin
            // The fetch still drains on the port; only its completion pulse is dropped.
            kill_reg <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (MEM_RDY) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
          mem_we_reg  <= 1'b0;
          kill_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign IF_RDY   = (state_reg == BUSY_IF) && MEM_RDY && !kill_reg && !IF_KILL;
  assign DM_RDY   = (state_reg == BUSY_DM) && MEM_RDY;
  assign IF_RDATA = MEM_RDATA;
  assign DM_RDATA = MEM_RDATA;
  assign IF_STALL = IF_REQ && !IF_RDY;
  assign DM_STALL = DM_REQ && !DM_RDY;

  assign MEM_REQ   = mem_req_reg;
  assign MEM_WE    = mem_we_reg;
  assign MEM_ADDR  = mem_addr_reg;
  assign MEM_WDATA = mem_wdata_reg;
  assign MEM_WSTRB = mem_wstrb_reg;

endmodule
